// File: rtl/arbitro_pkg.sv
// Shared constants and types for the round-robin arbiter slice.
package arbitro_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic {
    OCIOSO    = 1'b0,
    CONCEDIDO = 1'b1
  } estado_e;

  // Next search start after an owner leaves; wraps 7 -> 0 naturally.
  function automatic logic [IDX_W-1:0] prox_idx(input logic [IDX_W-1:0] i);
    return i + IDX_W'(1);
  endfunction

endpackage

// File: rtl/arbitro_rr_decodificador.sv
// 3-to-8 one-hot decoder with enable; output is all zeros when disabled.
module decodificador
  import arbitro_pkg::*;
(
  input  logic [IDX_W-1:0] a,
  input  logic             enable,
  output logic [N_REQ-1:0] y
);

  always_comb begin
    y = '0;
    if (enable) y[a] = 1'b1;
  end

endmodule

// File: rtl/arbitro_rr.sv
// Round-robin arbiter over 8 requesters with a per-ownership hold-time limit.
// The grant is decoded purely from registered state, so req never reaches gnt combinationally.
module arbitro_rr
  import arbitro_pkg::*;
#(
  parameter int unsigned MAX_CICLOS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valido,
  output logic             forcado
);

  localparam logic [7:0] ContMax = 8'(MAX_CICLOS - 1);

  estado_e          estado_q, estado_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [7:0]       cont_q, cont_d;
  logic             forcado_q, forcado_d;

  logic [N_REQ-1:0] req_rot;
  logic [IDX_W-1:0] desloc;
  logic [IDX_W-1:0] vencedor;
  logic             hay_req;

  // Rotate so bit 0 is the requester at ptr, then take the lowest set bit.
  always_comb begin
    req_rot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_rot[i] = req[ptr_q + IDX_W'(i)];
    end
    desloc  = '0;
    hay_req = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        desloc  = IDX_W'(i);
        hay_req = 1'b1;
      end
    end
    vencedor = ptr_q + desloc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q  <= OCIOSO;
      idx_q     <= '0;
      ptr_q     <= '0;
      cont_q    <= '0;
      forcado_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      cont_q    <= cont_d;
      forcado_q <= forcado_d;
    end
  end

  always_comb begin
    estado_d  = estado_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    cont_d    = cont_q;
    forcado_d = 1'b0;
    case (estado_q)
      OCIOSO: begin
        if (hay_req) begin
          idx_d    = vencedor;
          cont_d   = '0;
          estado_d = CONCEDIDO;
        end
      end
      CONCEDIDO: begin
        // Release takes priority over timeout, so forcado stays low on a tie.
        if (!req[idx_q]) begin
          estado_d = OCIOSO;
          ptr_d    = prox_idx(idx_q);
        end else if (cont_q == ContMax) begin
          estado_d  = OCIOSO;
          ptr_d     = prox_idx(idx_q);
          forcado_d = 1'b1;
        end else begin
          cont_d = cont_q + 8'd1;
        end
      end
      default: estado_d = OCIOSO;
    endcase
  end

  always_comb begin
    gnt_valido = (estado_q == CONCEDIDO);
    gnt_idx    = idx_q;
    forcado    = forcado_q;
  end

  decodificador u_decodificador (
    .a      (idx_q),
    .enable (gnt_valido),
    .y      (gnt)
  );

endmodule

// File: tb/tb_arbitro_rr.sv
// Directed bench for arbitro_rr; four instances share inputs with different hold limits.
module tb_arbitro_rr;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;

  logic [7:0] gnt16, gnt4, gnt3, gnt1;
  logic [2:0] idx16, idx4, idx3, idx1;
  logic       val16, val4, val3, val1;
  logic       frc16, frc4, frc3, frc1;

  int checks;
  int errors;

  arbitro_rr #(.MAX_CICLOS(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt16), .gnt_idx(idx16),
    .gnt_valido(val16), .forcado(frc16)
  );
  arbitro_rr #(.MAX_CICLOS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt4), .gnt_idx(idx4),
    .gnt_valido(val4), .forcado(frc4)
  );
  arbitro_rr #(.MAX_CICLOS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt3), .gnt_idx(idx3),
    .gnt_valido(val3), .forcado(frc3)
  );
  arbitro_rr #(.MAX_CICLOS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt1), .gnt_idx(idx1),
    .gnt_valido(val1), .forcado(frc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 8'h00;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 8'hFF;
    #1;
    checks++;
    if (gnt16 !== 8'h00 || val16 !== 1'b0 || idx16 !== 3'd0 || frc16 !== 1'b0) begin
      errors++;
      $display("FAIL reset_async gnt=%h val=%b idx=%0d frc=%b expected 00/0/0/0",
               gnt16, val16, idx16, frc16);
    end
    tick();
    tick();
    checks++;
    if (gnt16 !== 8'h00 || val16 !== 1'b0 || gnt4 !== 8'h00 || gnt1 !== 8'h00) begin
      errors++;
      $display("FAIL reset_held gnt16=%h val16=%b gnt4=%h gnt1=%h expected 00/0/00/00",
               gnt16, val16, gnt4, gnt1);
    end
    rst_n = 1'b1;
    req   = 8'h00;
    tick();
    tick();
    checks++;
    if (gnt16 !== 8'h00 || val16 !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle gnt=%h val=%b expected 00/0", gnt16, val16);
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 8'h04;
    tick();
    checks++;
    if (gnt16 !== 8'h04 || idx16 !== 3'd2 || val16 !== 1'b1) begin
      errors++;
      $display("FAIL single_grant gnt=%h idx=%0d val=%b expected 04/2/1", gnt16, idx16, val16);
    end
    req = 8'hFF;
    tick();
    checks++;
    if (gnt16 !== 8'h04) begin
      errors++;
      $display("FAIL single_others_ignored gnt=%h expected 04", gnt16);
    end
    req = 8'hFB;
    tick();
    checks++;
    if (gnt16 !== 8'h00 || val16 !== 1'b0 || idx16 !== 3'd2 || frc16 !== 1'b0) begin
      errors++;
      $display("FAIL single_release gnt=%h val=%b idx=%0d frc=%b expected 00/0/2/0",
               gnt16, val16, idx16, frc16);
    end
    tick();
    checks++;
    if (gnt16 !== 8'h08 || idx16 !== 3'd3) begin
      errors++;
      $display("FAIL single_next_from_ptr gnt=%h idx=%0d expected 08/3", gnt16, idx16);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] expg;
    logic [2:0] o;
    do_reset();
    req = 8'hFF;
    tick();
    for (int k = 0; k < 9; k++) begin
      o    = 3'(k % 8);
      expg = 8'h01 << o;
      checks++;
      if (gnt16 !== expg || idx16 !== o) begin
        errors++;
        $display("FAIL rr_grant k=%0d gnt=%h idx=%0d expected %h/%0d", k, gnt16, idx16, expg, o);
      end
      tick();
      checks++;
      if (gnt16 !== expg) begin
        errors++;
        $display("FAIL rr_hold k=%0d gnt=%h expected %h", k, gnt16, expg);
      end
      req = ~expg;
      tick();
      checks++;
      if (gnt16 !== 8'h00) begin
        errors++;
        $display("FAIL rr_idle k=%0d gnt=%h expected 00", k, gnt16);
      end
      req = 8'hFF;
      tick();
    end
  endtask

  task automatic test_timeout();
    logic [7:0] expg;
    do_reset();
    req = 8'h81;
    for (int r = 0; r < 3; r++) begin
      expg = (r == 1) ? 8'h80 : 8'h01;
      for (int c = 0; c < 4; c++) begin
        tick();
        checks++;
        if (gnt4 !== expg || frc4 !== 1'b0) begin
          errors++;
          $display("FAIL timeout_hold r=%0d c=%0d gnt=%h frc=%b expected %h/0",
                   r, c, gnt4, frc4, expg);
        end
      end
      tick();
      checks++;
      if (gnt4 !== 8'h00 || frc4 !== 1'b1) begin
        errors++;
        $display("FAIL timeout_forcado r=%0d gnt=%h frc=%b expected 00/1", r, gnt4, frc4);
      end
    end
  endtask

  task automatic test_sole_rewin();
    do_reset();
    req = 8'h20;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 3; c++) begin
        tick();
        checks++;
        if (gnt3 !== 8'h20 || idx3 !== 3'd5 || frc3 !== 1'b0) begin
          errors++;
          $display("FAIL sole_hold r=%0d c=%0d gnt=%h idx=%0d frc=%b expected 20/5/0",
                   r, c, gnt3, idx3, frc3);
        end
      end
      tick();
      checks++;
      if (gnt3 !== 8'h00 || frc3 !== 1'b1) begin
        errors++;
        $display("FAIL sole_forcado r=%0d gnt=%h frc=%b expected 00/1", r, gnt3, frc3);
      end
    end
  endtask

  task automatic test_max_one();
    logic [7:0] seq [5];
    seq[0] = 8'h01; seq[1] = 8'h00; seq[2] = 8'h80; seq[3] = 8'h00; seq[4] = 8'h01;
    do_reset();
    req = 8'h81;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (gnt1 !== seq[i] || frc1 !== (seq[i] == 8'h00)) begin
        errors++;
        $display("FAIL max_one i=%0d gnt=%h frc=%b expected %h/%b",
                 i, gnt1, frc1, seq[i], seq[i] == 8'h00);
      end
    end
  endtask

  task automatic test_release_vs_timeout();
    do_reset();
    req = 8'h01;
    for (int c = 0; c < 4; c++) tick();
    checks++;
    if (gnt4 !== 8'h01) begin
      errors++;
      $display("FAIL tie_last_cycle gnt=%h expected 01", gnt4);
    end
    req = 8'h00;
    tick();
    checks++;
    if (gnt4 !== 8'h00 || frc4 !== 1'b0) begin
      errors++;
      $display("FAIL tie_release_wins gnt=%h frc=%b expected 00/0", gnt4, frc4);
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 8'h10;
    tick();
    checks++;
    if (gnt16 !== 8'h10) begin
      errors++;
      $display("FAIL midrst_grant gnt=%h expected 10", gnt16);
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (gnt16 !== 8'h00 || val16 !== 1'b0 || idx16 !== 3'd0) begin
      errors++;
      $display("FAIL midrst_async gnt=%h val=%b idx=%0d expected 00/0/0", gnt16, val16, idx16);
    end
    tick();
    rst_n = 1'b1;
    req   = 8'h11;
    tick();
    checks++;
    if (gnt16 !== 8'h01 || idx16 !== 3'd0) begin
      errors++;
      $display("FAIL midrst_ptr_cleared gnt=%h idx=%0d expected 01/0", gnt16, idx16);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    req    = 8'h00;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_sole_rewin();
    test_max_one();
    test_release_vs_timeout();
    test_reset_mid_grant();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
